fpu_cmul_sequencer: RTL

- Sequences one shared single-precision FPU (combinational; add/sub/mul via 3-bit opcode) to perform the complex twiddle multiply of the radix-4 16-point FFT: y = a * w.
- Issues 4 multiplies, 1 subtract and 1 add in a fixed order, holding the partial products in internal registers.
- Sits between the butterfly datapath and the FPU instance. The FPU is instantiated by the parent and connected through the fpu_* ports.

---
 rtl/fft_fpu_pkg.sv | 23 ++
 rtl/fpu_cmul_sequencer.sv | 104 ++++++++++
 2 files changed

// File: rtl/fft_fpu_pkg.sv
// fft_fpu_pkg: shared FPU opcodes, FP constants and cmul sequencer state encoding
// Contents: OP_* opcodes of the shared FPU, FP_ONE/FP_ZERO bit patterns,
//           3-bit sequencer states, is_unity() twiddle test.
package fft_fpu_pkg;
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [31:0] FP_ONE  = 32'h3F800000;
    localparam logic [31:0] FP_ZERO = 32'h00000000;
    // Op states are consecutive so the sequencer advances with state + 1.
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_MUL_AC = 3'd1;
    localparam logic [2:0] ST_MUL_BD = 3'd2;
    localparam logic [2:0] ST_MUL_AD = 3'd3;
    localparam logic [2:0] ST_MUL_BC = 3'd4;
    localparam logic [2:0] ST_SUB_RE = 3'd5;
    localparam logic [2:0] ST_ADD_IM = 3'd6;
    localparam logic [2:0] ST_DONE   = 3'd7;
    // Exact bit compare: -0.0 in the imaginary part is not unity.
    function automatic logic is_unity(input logic [31:0] re, input logic [31:0] im);
        return re == FP_ONE && im == FP_ZERO;
    endfunction
endpackage

// File: rtl/fpu_cmul_sequencer.sv
// fpu_cmul_sequencer: complex multiply y = a * w on one shared combinational FPU
// Ports: clk/rst_n (async active-low); in_valid/in_ready + a_re/a_im/w_re/w_im
//        operand handshake; out_valid/out_ready + y_re/y_im result handshake;
//        fpu_in1/fpu_in2/fpu_opcode/fpu_en drive the parent's FPU, fpu_out returns.
module fpu_cmul_sequencer
    import fft_fpu_pkg::*;
#(
    parameter int FPU_WAIT     = 0,
    parameter bit BYPASS_UNITY = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a_re,
    input  logic [31:0] a_im,
    input  logic [31:0] w_re,
    input  logic [31:0] w_im,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] y_re,
    output logic [31:0] y_im,
    output logic [31:0] fpu_in1,
    output logic [31:0] fpu_in2,
    output logic [2:0]  fpu_opcode,
    output logic        fpu_en,
    input  logic [31:0] fpu_out
);
    logic [2:0]  state;
    logic [2:0]  cnt;
    logic        started;
    logic [31:0] ar, ai, wr, wi, p0, p1, p2, p3;
    logic        op_state, last, bypass;

    assign op_state  = state != ST_IDLE && state != ST_DONE;
    assign last      = cnt == 3'(FPU_WAIT);
    assign bypass    = BYPASS_UNITY && is_unity(w_re, w_im);
    // started keeps in_ready low until the first clock after reset release.
    assign in_ready  = started && state == ST_IDLE;
    assign out_valid = state == ST_DONE;
    assign fpu_en    = op_state;

    always_comb begin
        fpu_in1    = FP_ZERO;
        fpu_in2    = FP_ZERO;
        fpu_opcode = OP_ADD;
        case (state)
            ST_MUL_AC: begin fpu_in1 = ar; fpu_in2 = wr; fpu_opcode = OP_MUL; end
            ST_MUL_BD: begin fpu_in1 = ai; fpu_in2 = wi; fpu_opcode = OP_MUL; end
            ST_MUL_AD: begin fpu_in1 = ar; fpu_in2 = wi; fpu_opcode = OP_MUL; end
            ST_MUL_BC: begin fpu_in1 = ai; fpu_in2 = wr; fpu_opcode = OP_MUL; end
            ST_SUB_RE: begin fpu_in1 = p0; fpu_in2 = p1; fpu_opcode = OP_SUB; end
            ST_ADD_IM: begin fpu_in1 = p2; fpu_in2 = p3; fpu_opcode = OP_ADD; end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            started <= 1'b0;
            ar      <= '0;
            ai      <= '0;
            wr      <= '0;
            wi      <= '0;
            p0      <= '0;
            p1      <= '0;
            p2      <= '0;
            p3      <= '0;
            y_re    <= '0;
            y_im    <= '0;
        end else begin
            started <= 1'b1;
            if (in_ready && in_valid) begin
                ar    <= a_re;
                ai    <= a_im;
                wr    <= w_re;
                wi    <= w_im;
                state <= bypass ? ST_DONE : ST_MUL_AC;
                if (bypass) begin
                    y_re <= a_re;
                    y_im <= a_im;
                end
            end else if (op_state) begin
                cnt <= last ? 3'd0 : cnt + 3'd1;
                if (last) begin
                    state <= state + 3'd1;
                    case (state)
                        ST_MUL_AC: p0   <= fpu_out;
                        ST_MUL_BD: p1   <= fpu_out;
                        ST_MUL_AD: p2   <= fpu_out;
                        ST_MUL_BC: p3   <= fpu_out;
                        ST_SUB_RE: y_re <= fpu_out;
                        ST_ADD_IM: y_im <= fpu_out;
                        default: ;
                    endcase
                end
            end else if (out_valid && out_ready) begin
                state <= ST_IDLE;
            end
        end
    end
endmodule
